// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor.
//   - pll_sup_state_e : supervisor state encoding
//   - RELOCK_W/RETRY_W: widths of the relock and retry counters
//   - DEF_*           : default cycle counts for the 50 MHz board clock
//   - sat_inc         : saturating increment for 8-bit status counters
package pll_sup_pkg;

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      DEBOUNCE  = 3'd2,
      RUN       = 3'd3,
      FAIL      = 3'd4
   } pll_sup_state_e;

   localparam int unsigned RELOCK_W = 8;
   localparam int unsigned RETRY_W  = 8;

   // 50 MHz board clock: 1 ms lock window, ~20 us stability window
   localparam int unsigned DEF_RST_CYCLES    = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
   localparam int unsigned DEF_STABLE_CYCLES = 1024;
   localparam int unsigned DEF_MAX_RETRY     = 8;
   localparam int unsigned DEF_CNT_W         = 16;

   function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] v);
      return (v == '1) ? v : v + RELOCK_W'(1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for slow status bits crossing into clk.
//   clk   : destination clock
//   rst_n : async active-low reset, both stages clear to 0
//   i_d   : asynchronous input
//   o_q   : synchronized output, two clk cycles of latency
module sync_2ff #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies the asynchronous lock
// indication, and releases the downstream domain reset only after lock has
// been stable. Runs on the board clock that also feeds the PLL input.
//   clk        : free-running 50 MHz board clock
//   rst_n      : async active-low reset
//   pll_lock   : PLL lock, asynchronous to clk
//   clr_sticky : one-cycle pulse clearing lock_lost
//   pll_rst    : PLL RST, active high
//   dom_rst_n  : downstream domain reset, active low
//   locked     : high while running on a qualified lock
//   lock_lost  : sticky, lock dropped while running
//   relock_cnt : saturating count of lock losses while running
//   pll_fail   : retry limit exhausted (0 unless feature enabled)
// Optional feature macro: PLL_LOCK_SUP_RETRY_LIMIT_EN (retry limit + FAIL state).
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pll_lock,
   input  logic                clr_sticky,
   output logic                pll_rst,
   output logic                dom_rst_n,
   output logic                locked,
   output logic                lock_lost,
   output logic [RELOCK_W-1:0] relock_cnt,
   output logic                pll_fail
);

   pll_sup_state_e      r_state;
   pll_sup_state_e      w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                r_pll_rst;
   logic                r_dom_rst_n;
   logic                r_locked;
   logic                r_lock_lost;
   logic                w_lock_lost_nxt;
   logic [RELOCK_W-1:0] r_relock_cnt;
   logic [RELOCK_W-1:0] w_relock_cnt_nxt;
   logic                w_lock_s;

`ifdef PLL_LOCK_SUP_RETRY_LIMIT_EN
   logic [RETRY_W-1:0]  r_retry;
   logic [RETRY_W-1:0]  w_retry_nxt;
   logic [RETRY_W-1:0]  w_retry_inc;
   logic                r_pll_fail;
`else
   logic                w_unused_cfg;
   assign w_unused_cfg = ^MAX_RETRY;
`endif

   // Lock crosses in from the PLL's analog domain
   sync_2ff #(.W(1)) u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (pll_lock),
      .o_q   (w_lock_s)
   );

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= RESET_PLL;
         r_cnt        <= '0;
         r_pll_rst    <= 1'b1;
         r_dom_rst_n  <= 1'b0;
         r_locked     <= 1'b0;
         r_lock_lost  <= 1'b0;
         r_relock_cnt <= '0;
`ifdef PLL_LOCK_SUP_RETRY_LIMIT_EN
         r_retry      <= '0;
         r_pll_fail   <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         // Outputs follow the next state so they move on the transition edge
         r_pll_rst    <= (w_state_nxt == RESET_PLL) || (w_state_nxt == FAIL);
         r_dom_rst_n  <= (w_state_nxt == RUN);
         r_locked     <= (w_state_nxt == RUN);
         r_lock_lost  <= w_lock_lost_nxt;
         r_relock_cnt <= w_relock_cnt_nxt;
`ifdef PLL_LOCK_SUP_RETRY_LIMIT_EN
         r_retry      <= w_retry_nxt;
         r_pll_fail   <= (w_state_nxt == FAIL);
`endif
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_relock_cnt_nxt = r_relock_cnt;
      // Clear applies unless a loss below sets the flag on the same edge
      w_lock_lost_nxt  = clr_sticky ? 1'b0 : r_lock_lost;
`ifdef PLL_LOCK_SUP_RETRY_LIMIT_EN
      w_retry_nxt      = r_retry;
      w_retry_inc      = (r_retry == '1) ? r_retry : r_retry + RETRY_W'(1);
`endif

      case (r_state)
         RESET_PLL: begin
            if (r_cnt == CNT_W'(RST_CYCLES - 32'd1)) begin
               w_state_nxt = WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end

         WAIT_LOCK: begin
            if (w_lock_s) begin
               w_state_nxt = DEBOUNCE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 32'd1)) begin
               w_cnt_nxt   = '0;
`ifdef PLL_LOCK_SUP_RETRY_LIMIT_EN
               w_retry_nxt = w_retry_inc;
               w_state_nxt = (w_retry_inc >= RETRY_W'(MAX_RETRY)) ? FAIL : RESET_PLL;
`else
               w_state_nxt = RESET_PLL;
`endif
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end

         DEBOUNCE: begin
            // Any drop restarts qualification, including the lock timeout
            if (!w_lock_s) begin
               w_state_nxt = WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_W'(STABLE_CYCLES - 32'd1)) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
`ifdef PLL_LOCK_SUP_RETRY_LIMIT_EN
               w_retry_nxt = '0;
`endif
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end

         RUN: begin
            if (!w_lock_s) begin
               w_state_nxt      = RESET_PLL;
               w_cnt_nxt        = '0;
               w_lock_lost_nxt  = 1'b1;
               w_relock_cnt_nxt = sat_inc(r_relock_cnt);
            end
         end

`ifdef PLL_LOCK_SUP_RETRY_LIMIT_EN
         FAIL: begin
            // Terminal until rst_n
            w_cnt_nxt = '0;
         end
`endif

         default: begin
            w_state_nxt = RESET_PLL;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign pll_rst    = r_pll_rst;
   assign dom_rst_n  = r_dom_rst_n;
   assign locked     = r_locked;
   assign lock_lost  = r_lock_lost;
   assign relock_cnt = r_relock_cnt;
`ifdef PLL_LOCK_SUP_RETRY_LIMIT_EN
   assign pll_fail   = r_pll_fail;
`else
   assign pll_fail   = 1'b0;
`endif

endmodule
